vga_timing_gen: RTL and testbench

Raster timing generator for the 1280x720@60 VGA path. It produces the pixel/line counters and the sync strobes that the pixel generator consumes: h_counter, v_counter and v_sync, with v_sync also used as that stage's frame-rate clock. It also provides h_sync, a display-enable and a frame-start pulse for the output/DAC stage. Horizontal and vertical phase sequencing is implemented as two cascaded counter state machines.

---
 rtl/vga_timing_gen_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 69 ++++++
 rtl/vga_timing_gen.sv | 86 ++++++++
 tb/tb_vga_timing_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing definitions for the 720p60 timing generator and the pixel generator.
// Constants and types only: no latency, no flow control.
package vga_timing_gen_pkg;

    localparam int DEF_H_ACTIVE_PIXEL_COUNT = 1280;
    localparam int DEF_H_FRONT_PORCH        = 110;
    localparam int DEF_H_SYNC_WIDTH         = 40;
    localparam int DEF_H_BACK_PORCH         = 220;

    localparam int DEF_V_ACTIVE_LINE_COUNT  = 720;
    localparam int DEF_V_FRONT_PORCH        = 5;
    localparam int DEF_V_SYNC_WIDTH         = 5;
    localparam int DEF_V_BACK_PORCH         = 20;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE_PIXEL_COUNT + DEF_H_FRONT_PORCH
                               + DEF_H_SYNC_WIDTH + DEF_H_BACK_PORCH;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE_LINE_COUNT + DEF_V_FRONT_PORCH
                               + DEF_V_SYNC_WIDTH + DEF_V_BACK_PORCH;

    // Counter width shared by both axes; each axis period must fit in it.
    localparam int CNT_W         = 12;
    localparam int CNT_MAX_TOTAL = 1 << CNT_W;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vga_phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM, advancing on step.
// count is registered; phase and wrap are the combinational next-phase and wrap for this edge.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_ACTIVE_PIXEL_COUNT,
    parameter int FRONT_LEN  = DEF_H_FRONT_PORCH,
    parameter int SYNC_LEN   = DEF_H_SYNC_WIDTH,
    parameter int BACK_LEN   = DEF_H_BACK_PORCH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output vga_phase_t       phase,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE_LEN - 1);
    localparam logic [CNT_W-1:0] FRONT_END  = CNT_W'(ACTIVE_LEN + FRONT_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);

    if (TOTAL > CNT_MAX_TOTAL) begin : g_total_check
        $error("vga_axis_counter: axis period %0d exceeds counter range", TOTAL);
    end

    vga_phase_t       state_q;
    vga_phase_t       state_d;
    logic [CNT_W-1:0] count_d;

    // Reset parks the axis on its last position so the first step lands on 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BACK;
            count   <= LAST;
        end else begin
            state_q <= state_d;
            count   <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count;
        wrap    = 1'b0;
        if (step) begin
            if (count == LAST) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count + 1'b1;
            end
            case (state_q)
                ACTIVE:  if (count == ACTIVE_END) state_d = FRONT;
                FRONT:   if (count == FRONT_END)  state_d = SYNC;
                SYNC:    if (count == SYNC_END)   state_d = BACK;
                BACK:    if (count == LAST)       state_d = ACTIVE;
                default: state_d = BACK;
            endcase
        end
    end

    // Exposing the next phase lets the parent register flags aligned with count.
    assign phase = state_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, syncs, display-enable and frame-start, all registered.
// Outputs update on the pix_en edge they describe (zero skew); pix_en=0 freezes everything.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE_PIXEL_COUNT = DEF_H_ACTIVE_PIXEL_COUNT,
    parameter int H_FRONT_PORCH        = DEF_H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH         = DEF_H_SYNC_WIDTH,
    parameter int H_BACK_PORCH         = DEF_H_BACK_PORCH,
    parameter int V_ACTIVE_LINE_COUNT  = DEF_V_ACTIVE_LINE_COUNT,
    parameter int V_FRONT_PORCH        = DEF_V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH         = DEF_V_SYNC_WIDTH,
    parameter int V_BACK_PORCH         = DEF_V_BACK_PORCH,
    parameter bit H_SYNC_POL           = 1'b1,
    parameter bit V_SYNC_POL           = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_counter,
    output logic [CNT_W-1:0] v_counter,
    output logic             h_sync,
    output logic             v_sync,
    output logic             active,
    output logic             frame_start
);

    localparam logic H_ON  = H_SYNC_POL;
    localparam logic H_OFF = ~H_SYNC_POL;
    localparam logic V_ON  = V_SYNC_POL;
    localparam logic V_OFF = ~V_SYNC_POL;

    vga_phase_t h_phase_nxt;
    vga_phase_t v_phase_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic       v_step;

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE_PIXEL_COUNT),
        .FRONT_LEN  (H_FRONT_PORCH),
        .SYNC_LEN   (H_SYNC_WIDTH),
        .BACK_LEN   (H_BACK_PORCH)
    ) u_h_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (pix_en),
        .count (h_counter),
        .phase (h_phase_nxt),
        .wrap  (h_wrap)
    );

    assign v_step = h_wrap & pix_en;

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE_LINE_COUNT),
        .FRONT_LEN  (V_FRONT_PORCH),
        .SYNC_LEN   (V_SYNC_WIDTH),
        .BACK_LEN   (V_BACK_PORCH)
    ) u_v_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (v_step),
        .count (v_counter),
        .phase (v_phase_nxt),
        .wrap  (v_wrap)
    );

    // Flags are decoded from next-phase so they land on the same edge as the counters.
    // With pix_en low the next phase equals the current one, so they hold naturally;
    // v_wrap already implies an enabled horizontal wrap, i.e. the step onto (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_sync      <= H_OFF;
            v_sync      <= V_OFF;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= (h_phase_nxt == SYNC) ? H_ON : H_OFF;
            v_sync      <= (v_phase_nxt == SYNC) ? V_ON : V_OFF;
            active      <= (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset/line timing, reduced-size instances for frame checks.
module tb_vga_timing_gen;

    localparam int SHA = 16, SHF = 4, SHS = 3, SHB = 5;
    localparam int SVA = 6,  SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHA + SHF + SHS + SHB;   // 28
    localparam int SVT = SVA + SVF + SVS + SVB;   // 13

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    logic [11:0] d_h, d_v, s_h, s_v, n_h, n_v;
    logic d_hs, d_vs, d_act, d_fs;
    logic s_hs, s_vs, s_act, s_fs;
    logic n_hs, n_vs, n_act, n_fs;

    int errors = 0;
    int checks = 0;

    // Reference position of the reduced-size instances
    int   mh = SHT - 1;
    int   mv = SVT - 1;
    logic mfs = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(d_h), .v_counter(d_v), .h_sync(d_hs), .v_sync(d_vs),
        .active(d_act), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE_PIXEL_COUNT(SHA), .H_FRONT_PORCH(SHF), .H_SYNC_WIDTH(SHS), .H_BACK_PORCH(SHB),
        .V_ACTIVE_LINE_COUNT(SVA), .V_FRONT_PORCH(SVF), .V_SYNC_WIDTH(SVS), .V_BACK_PORCH(SVB)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(s_h), .v_counter(s_v), .h_sync(s_hs), .v_sync(s_vs),
        .active(s_act), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE_PIXEL_COUNT(SHA), .H_FRONT_PORCH(SHF), .H_SYNC_WIDTH(SHS), .H_BACK_PORCH(SHB),
        .V_ACTIVE_LINE_COUNT(SVA), .V_FRONT_PORCH(SVF), .V_SYNC_WIDTH(SVS), .V_BACK_PORCH(SVB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) u_inv (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(n_h), .v_counter(n_v), .h_sync(n_hs), .v_sync(n_vs),
        .active(n_act), .frame_start(n_fs)
    );

    // Advance n clocks, tracking the reduced raster; returns just after a falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst) begin
                mh = SHT - 1; mv = SVT - 1; mfs = 1'b0;
            end else if (pix_en) begin
                if (mh == SHT - 1) begin
                    mh = 0;
                    mv = (mv == SVT - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
                mfs = (mh == 0) && (mv == 0);
            end else begin
                mfs = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; pix_en = 1'b1;
        tick(2);
        checks++; if (d_h !== 12'd1649 || d_v !== 12'd749) begin errors++;
            $display("FAIL reset_cnt got=(%0d,%0d) exp=(1649,749)", d_h, d_v); end
        checks++; if ({d_hs, d_vs, d_act, d_fs} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags got hs/vs/act/fs=%b exp=0000", {d_hs, d_vs, d_act, d_fs}); end
        checks++; if (s_h !== 12'd27 || s_v !== 12'd12) begin errors++;
            $display("FAIL reset_small_cnt got=(%0d,%0d) exp=(27,12)", s_h, s_v); end
        checks++; if ({n_hs, n_vs, n_act} !== 3'b110) begin errors++;
            $display("FAIL reset_inv_sync got hs/vs/act=%b exp=110", {n_hs, n_vs, n_act}); end
        rst = 1'b1;
        tick(1);
        checks++; if (d_h !== 12'd0 || d_v !== 12'd0 || d_fs !== 1'b1 || d_act !== 1'b1) begin errors++;
            $display("FAIL first_edge got=(%0d,%0d) fs=%b act=%b exp=(0,0) fs=1 act=1", d_h, d_v, d_fs, d_act); end
        checks++; if (s_h !== 12'd0 || s_v !== 12'd0 || s_fs !== 1'b1) begin errors++;
            $display("FAIL first_edge_small got=(%0d,%0d) fs=%b exp=(0,0) fs=1", s_h, s_v, s_fs); end
    endtask

    task automatic test_line;
        tick(1);
        checks++; if (d_fs !== 1'b0 || d_h !== 12'd1) begin errors++;
            $display("FAIL line_fs_drop got h=%0d fs=%b exp h=1 fs=0", d_h, d_fs); end
        tick(1278);
        checks++; if (d_h !== 12'd1279 || d_act !== 1'b1) begin errors++;
            $display("FAIL line_last_active got h=%0d act=%b exp h=1279 act=1", d_h, d_act); end
        tick(1);
        checks++; if (d_h !== 12'd1280 || d_act !== 1'b0) begin errors++;
            $display("FAIL line_active_fall got h=%0d act=%b exp h=1280 act=0", d_h, d_act); end
        tick(109);
        checks++; if (d_h !== 12'd1389 || d_hs !== 1'b0) begin errors++;
            $display("FAIL line_pre_hsync got h=%0d hs=%b exp h=1389 hs=0", d_h, d_hs); end
        tick(1);
        checks++; if (d_h !== 12'd1390 || d_hs !== 1'b1) begin errors++;
            $display("FAIL line_hsync_rise got h=%0d hs=%b exp h=1390 hs=1", d_h, d_hs); end
        tick(39);
        checks++; if (d_h !== 12'd1429 || d_hs !== 1'b1) begin errors++;
            $display("FAIL line_hsync_last got h=%0d hs=%b exp h=1429 hs=1", d_h, d_hs); end
        tick(1);
        checks++; if (d_h !== 12'd1430 || d_hs !== 1'b0) begin errors++;
            $display("FAIL line_hsync_fall got h=%0d hs=%b exp h=1430 hs=0", d_h, d_hs); end
        tick(219);
        checks++; if (d_h !== 12'd1649 || d_v !== 12'd0) begin errors++;
            $display("FAIL line_end got=(%0d,%0d) exp=(1649,0)", d_h, d_v); end
        tick(1);
        checks++; if (d_h !== 12'd0 || d_v !== 12'd1 || d_act !== 1'b1 || d_fs !== 1'b0) begin errors++;
            $display("FAIL line_wrap got=(%0d,%0d) act=%b fs=%b exp=(0,1) act=1 fs=0", d_h, d_v, d_act, d_fs); end
    endtask

    task automatic test_frame;
        int   fs_seen = 0;
        int   vs_high = 0;
        logic e_act, e_hs, e_vs;
        pix_en = 1'b1;
        for (int i = 0; i < SHT * SVT; i++) begin
            tick(1);
            e_act = (mh < SHA) && (mv < SVA);
            e_hs  = (mh >= SHA + SHF) && (mh < SHA + SHF + SHS);
            e_vs  = (mv >= SVA + SVF) && (mv < SVA + SVF + SVS);
            if (s_fs === 1'b1) fs_seen++;
            if (s_vs === 1'b1) vs_high++;
            checks++; if (s_h !== 12'(mh) || s_v !== 12'(mv)) begin errors++;
                $display("FAIL frame_cnt got=(%0d,%0d) exp=(%0d,%0d)", s_h, s_v, mh, mv); end
            checks++; if ({s_act, s_hs, s_vs, s_fs} !== {e_act, e_hs, e_vs, mfs}) begin errors++;
                $display("FAIL frame_flags at (%0d,%0d) got act/hs/vs/fs=%b exp=%b",
                         mh, mv, {s_act, s_hs, s_vs, s_fs}, {e_act, e_hs, e_vs, mfs}); end
            checks++; if ({n_hs, n_vs} !== {~e_hs, ~e_vs}) begin errors++;
                $display("FAIL frame_inv_sync at (%0d,%0d) got hs/vs=%b exp=%b",
                         mh, mv, {n_hs, n_vs}, {~e_hs, ~e_vs}); end
        end
        checks++; if (fs_seen != 1) begin errors++;
            $display("FAIL frame_start_count got=%0d exp=1", fs_seen); end
        checks++; if (vs_high != SVS * SHT) begin errors++;
            $display("FAIL vsync_cycles got=%0d exp=%0d", vs_high, SVS * SHT); end
    endtask

    task automatic test_midreset;
        pix_en = 1'b1;
        for (int k = 0; k < 2 * SHT * SVT && !(mh == 21 && mv == 8); k++) tick(1);
        checks++; if (s_h !== 12'd21 || s_v !== 12'd8 || s_hs !== 1'b1 || s_vs !== 1'b1) begin errors++;
            $display("FAIL pre_reset got=(%0d,%0d) hs=%b vs=%b exp=(21,8) hs=1 vs=1", s_h, s_v, s_hs, s_vs); end
        rst = 1'b0;
        #1;
        checks++; if (s_h !== 12'd27 || s_v !== 12'd12 || {s_hs, s_vs, s_act, s_fs} !== 4'b0000) begin errors++;
            $display("FAIL async_reset got=(%0d,%0d) flags=%b exp=(27,12) flags=0000",
                     s_h, s_v, {s_hs, s_vs, s_act, s_fs}); end
        checks++; if ({n_hs, n_vs} !== 2'b11 || d_h !== 12'd1649 || d_v !== 12'd749) begin errors++;
            $display("FAIL async_reset_other got inv hs/vs=%b dut=(%0d,%0d) exp 11 (1649,749)",
                     {n_hs, n_vs}, d_h, d_v); end
        tick(3);
        checks++; if (s_h !== 12'd27 || s_v !== 12'd12 || s_act !== 1'b0) begin errors++;
            $display("FAIL reset_hold got=(%0d,%0d) act=%b exp=(27,12) act=0", s_h, s_v, s_act); end
        rst = 1'b1;
        tick(1);
        checks++; if (s_h !== 12'd0 || s_v !== 12'd0 || s_fs !== 1'b1 || s_act !== 1'b1) begin errors++;
            $display("FAIL recover got=(%0d,%0d) fs=%b act=%b exp=(0,0) fs=1 act=1", s_h, s_v, s_fs, s_act); end
        checks++; if (d_h !== 12'd0 || d_v !== 12'd0 || d_fs !== 1'b1) begin errors++;
            $display("FAIL recover_dut got=(%0d,%0d) fs=%b exp=(0,0) fs=1", d_h, d_v, d_fs); end
    endtask

    task automatic test_pix_en;
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pix_en = (i % 2 == 0);
            tick(1);
            checks++; if (d_h !== 12'(i / 2) || d_v !== 12'd0) begin errors++;
                $display("FAIL pix_en_cnt step=%0d got=(%0d,%0d) exp=(%0d,0)", i, d_h, d_v, i / 2); end
            checks++; if (d_fs !== (i == 0) || d_act !== 1'b1 || d_hs !== 1'b0) begin errors++;
                $display("FAIL pix_en_flags step=%0d got fs/act/hs=%b%b%b exp=%b10",
                         i, d_fs, d_act, d_hs, (i == 0)); end
            checks++; if (s_h !== 12'(mh) || s_fs !== mfs) begin errors++;
                $display("FAIL pix_en_small step=%0d got h=%0d fs=%b exp h=%0d fs=%b", i, s_h, s_fs, mh, mfs); end
        end
        pix_en = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        pix_en = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_midreset();
        test_pix_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
